// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback stage.
package wb_pkg;

    localparam int unsigned WbAddrWidth = 3;
    localparam int unsigned WbDataWidth = 32;

    typedef struct packed {
        logic [WbAddrWidth-1:0] addr;
        logic [WbDataWidth-1:0] data;
    } wb_req_t;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer-side and register-file-side signals of the writeback stage.
// The slave modport is the writeback block; the master modport is its environment.
interface regfile_writeback_if #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  src0_valid;
    logic [ADDR_WIDTH-1:0] src0_addr;
    logic [DATA_WIDTH-1:0] src0_data;
    logic                  src0_ready;
    logic                  src1_valid;
    logic [ADDR_WIDTH-1:0] src1_addr;
    logic [DATA_WIDTH-1:0] src1_data;
    logic                  src1_ready;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  idle;

    modport master (
        output src0_valid, src0_addr, src0_data, src1_valid, src1_addr, src1_data, wr_ready,
        input  src0_ready, src1_ready, wr_valid, wr_addr, wr_data, idle
    );

    modport slave (
        input  src0_valid, src0_addr, src0_data, src1_valid, src1_addr, src1_data, wr_ready,
        output src0_ready, src1_ready, wr_valid, wr_addr, wr_data, idle
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO with full/empty flags; a push while full is ignored even if popping.
module wb_fifo #(
    parameter type         req_t      = wb_pkg::wb_req_t,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  req_t data_i,
    input  logic pop_i,
    output req_t head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    logic [PtrW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    req_t          mem_q [FIFO_DEPTH];
    logic          push_en, pop_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: two buffered producers, round-robin arbitration, x0 drop, one write/cycle.
// Optional WB_BYPASS_EN adds two combinational forwarding ports off the output register.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WbAddrWidth,
    parameter int unsigned DATA_WIDTH = WbDataWidth,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_WIDTH-1:0] byp_addr_a,
    input  logic [ADDR_WIDTH-1:0] byp_addr_b,
    output logic                  byp_hit_a,
    output logic                  byp_hit_b,
    output logic [DATA_WIDTH-1:0] byp_data_a,
    output logic [DATA_WIDTH-1:0] byp_data_b,
`endif
    regfile_writeback_if.slave    bus
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t head0, head1, head_sel;
    logic full0, full1, empty0, empty1;
    logic pop0, pop1;
    logic sel, any_head, hold, is_x0, grant, load;

    logic                  rr_q, rr_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    wb_fifo #(
        .req_t      (req_t),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo_alu (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.src0_valid),
        .data_i  ({bus.src0_addr, bus.src0_data}),
        .pop_i   (pop0),
        .head_o  (head0),
        .full_o  (full0),
        .empty_o (empty0)
    );

    wb_fifo #(
        .req_t      (req_t),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo_lsu (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.src1_valid),
        .data_i  ({bus.src1_addr, bus.src1_data}),
        .pop_i   (pop1),
        .head_o  (head1),
        .full_o  (full1),
        .empty_o (empty1)
    );

    // The rr-pointed source wins when it has a head, otherwise the other one.
    always_comb begin
        sel = rr_q;
        if (rr_q == SRC_ALU && empty0) sel = SRC_LSU;
        if (rr_q == SRC_LSU && empty1) sel = SRC_ALU;
    end

    assign head_sel = (sel == SRC_LSU) ? head1 : head0;
    assign any_head = ~empty0 | ~empty1;
    assign hold     = wr_valid_q & ~bus.wr_ready;
    assign is_x0    = (head_sel.addr == '0);
    // x0 heads are discarded even while the output register is held.
    assign grant    = any_head & (is_x0 | ~hold);
    assign load     = grant & ~is_x0;
    assign pop0     = grant & (sel == SRC_ALU);
    assign pop1     = grant & (sel == SRC_LSU);
    assign rr_d     = grant ? ~rr_q : rr_q;

    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (load) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = head_sel.addr;
            wr_data_d  = head_sel.data;
        end else if (wr_valid_q && bus.wr_ready) begin
            wr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= SRC_ALU;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            rr_q       <= rr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.src0_ready = ~full0;
    assign bus.src1_ready = ~full1;
    assign bus.wr_valid   = wr_valid_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.idle       = empty0 & empty1 & ~wr_valid_q;

`ifdef WB_BYPASS_EN
    assign byp_hit_a  = wr_valid_q & (wr_addr_q == byp_addr_a) & (byp_addr_a != '0);
    assign byp_hit_b  = wr_valid_q & (wr_addr_q == byp_addr_b) & (byp_addr_b != '0);
    assign byp_data_a = byp_hit_a ? wr_data_q : '0;
    assign byp_data_b = byp_hit_b ? wr_data_q : '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback; writes accepted by the register file
// are logged by a monitor and compared against hand-computed sequences.
module tb_regfile_writeback;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [AW+DW-1:0] wr_log [$];

    regfile_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef WB_BYPASS_EN
    logic [AW-1:0] byp_addr_a, byp_addr_b;
    logic          byp_hit_a, byp_hit_b;
    logic [DW-1:0] byp_data_a, byp_data_b;
`endif

    regfile_writeback #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef WB_BYPASS_EN
        .byp_addr_a (byp_addr_a),
        .byp_addr_b (byp_addr_b),
        .byp_hit_a  (byp_hit_a),
        .byp_hit_b  (byp_hit_b),
        .byp_data_a (byp_data_a),
        .byp_data_b (byp_data_b),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after posedge, so negedge sees what the next posedge will use.
    always @(negedge clk) begin
        if (!rst && bus.wr_valid && bus.wr_ready) wr_log.push_back({bus.wr_addr, bus.wr_data});
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.src0_valid = 1'b0;
        bus.src1_valid = 1'b0;
        bus.src0_addr  = '0;
        bus.src0_data  = '0;
        bus.src1_addr  = '0;
        bus.src1_data  = '0;
        bus.wr_ready   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wr_log.delete();
    endtask

    task automatic push0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.src0_valid = 1'b1;
        bus.src0_addr  = a;
        bus.src0_data  = d;
    endtask

    task automatic push1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.src1_valid = 1'b1;
        bus.src1_addr  = a;
        bus.src1_data  = d;
    endtask

    initial begin
`ifdef WB_BYPASS_EN
        byp_addr_a = '0;
        byp_addr_b = '0;
`endif
        do_reset();

        // Reset state
        check_eq("rst_wr_valid", bus.wr_valid, 0);
        check_eq("rst_src0_ready", bus.src0_ready, 1);
        check_eq("rst_src1_ready", bus.src1_ready, 1);
        check_eq("rst_idle", bus.idle, 1);
        check_eq("rst_wr_addr", bus.wr_addr, 0);
        check_eq("rst_wr_data", bus.wr_data, 0);

        // Single write: push in cycle N, wr_valid in N+2
        push0(3'd5, 32'hDEADBEEF);
        tick();
        bus.src0_valid = 1'b0;
        check_eq("single_n1_valid", bus.wr_valid, 0);
        tick();
        check_eq("single_n2_valid", bus.wr_valid, 1);
        check_eq("single_addr", bus.wr_addr, 5);
        check_eq("single_data", bus.wr_data, 32'hDEADBEEF);
        tick();
        check_eq("single_after_valid", bus.wr_valid, 0);
        check_eq("single_idle", bus.idle, 1);
        check_eq("single_count", wr_log.size(), 1);

        // Round-robin starting with src0 after reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push0(3'd1, 32'h100 + i);
            push1(3'd2, 32'h200 + i);
            tick();
        end
        bus.src0_valid = 1'b0;
        bus.src1_valid = 1'b0;
        repeat (12) tick();
        check_eq("rr_enough", wr_log.size() >= 6, 1);
        for (int i = 0; i < 6; i++) begin
            logic [AW+DW-1:0] e;
            e = wr_log[i];
            check_eq($sformatf("rr_addr_%0d", i), e[AW+DW-1:DW], (i % 2 == 0) ? 1 : 2);
        end
        check_eq("rr_idle", bus.idle, 1);

        // Backpressure: wr_ready low for 6 cycles while src1 pushes 3 entries
        do_reset();
        bus.wr_ready = 1'b0;
        push1(3'd4, 32'hA1);
        tick();
        push1(3'd5, 32'hA2);
        tick();
        push1(3'd6, 32'hA3);
        tick();
        bus.src1_valid = 1'b0;
        check_eq("bp_src1_ready", bus.src1_ready, 0);
        check_eq("bp_valid", bus.wr_valid, 1);
        check_eq("bp_addr", bus.wr_addr, 4);
        check_eq("bp_data", bus.wr_data, 32'hA1);
        tick();
        tick();
        check_eq("bp_held_addr", bus.wr_addr, 4);
        check_eq("bp_held_data", bus.wr_data, 32'hA1);
        check_eq("bp_held_ready", bus.src1_ready, 0);
        check_eq("bp_none_yet", wr_log.size(), 0);
        tick();
        bus.wr_ready = 1'b1;
        repeat (6) tick();
        check_eq("bp_count", wr_log.size(), 3);
        check_eq("bp_w0", wr_log[0], {3'd4, 32'hA1});
        check_eq("bp_w1", wr_log[1], {3'd5, 32'hA2});
        check_eq("bp_w2", wr_log[2], {3'd6, 32'hA3});

        // x0 drop
        do_reset();
        push0(3'd0, 32'h1234);
        tick();
        push0(3'd3, 32'h55);
        tick();
        bus.src0_valid = 1'b0;
        repeat (6) tick();
        check_eq("x0_count", wr_log.size(), 1);
        check_eq("x0_write", wr_log[0], {3'd3, 32'h55});
        check_eq("x0_idle", bus.idle, 1);

        // Reset mid-flight with buffered entries and a held write
        do_reset();
        bus.wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push0(3'd1, 32'h300 + i);
            push1(3'd2, 32'h400 + i);
            tick();
        end
        bus.src0_valid = 1'b0;
        bus.src1_valid = 1'b0;
        check_eq("mid_valid_before", bus.wr_valid, 1);
        check_eq("mid_idle_before", bus.idle, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.wr_ready = 1'b1;
        wr_log.delete();
        check_eq("mid_valid", bus.wr_valid, 0);
        check_eq("mid_idle", bus.idle, 1);
        check_eq("mid_src0_ready", bus.src0_ready, 1);
        check_eq("mid_src1_ready", bus.src1_ready, 1);
        repeat (6) tick();
        check_eq("mid_no_stale", wr_log.size(), 0);

`ifdef WB_BYPASS_EN
        do_reset();
        bus.wr_ready = 1'b0;
        push0(3'd7, 32'hA5A5A5A5);
        tick();
        bus.src0_valid = 1'b0;
        tick();
        byp_addr_a = 3'd7;
        byp_addr_b = 3'd0;
        #1;
        check_eq("byp_hit_a", byp_hit_a, 1);
        check_eq("byp_data_a", byp_data_a, 32'hA5A5A5A5);
        check_eq("byp_hit_b", byp_hit_b, 0);
        check_eq("byp_data_b", byp_data_b, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
